// File: rtl/stopwatch_ctrl_if.sv
// Button/time-base inputs and BCD display/status outputs of the stopwatch
// control stage, bundled for connection between the debouncer side and the
// seven-segment scan driver side.
interface stopwatch_ctrl_if;
  logic       pb_debounced;
  logic       tick;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       running;
  logic       press_pulse;

  // Upstream side: drives the button level and tick, observes the display.
  modport master (
    output pb_debounced,
    output tick,
    input  sec_ones,
    input  sec_tens,
    input  min_ones,
    input  min_tens,
    input  running,
    input  press_pulse
  );

  // Stopwatch side: consumes button/tick, produces display and status.
  modport slave (
    input  pb_debounced,
    input  tick,
    output sec_ones,
    output sec_tens,
    output min_ones,
    output min_tens,
    output running,
    output press_pulse
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// MM:SS BCD stopwatch controller. A short press (release before the hold
// threshold) toggles run/pause; holding the button for LONG_TICKS ticks
// clears the count once and forces pause. The release that ends a long
// press is swallowed so it does not also toggle.
module stopwatch_ctrl #(
  parameter int unsigned LONG_TICKS = 2
) (
  input  logic           clk,
  input  logic           rst,
  stopwatch_ctrl_if.slave sw
);

  typedef enum logic {
    PAUSE = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [3:0] HOLD_LIMIT = 4'(LONG_TICKS);

  state_t      state_q, state_d;
  logic        pb_prev_q;
  logic [3:0]  hold_q, hold_d;
  logic        long_flag_q, long_flag_d;
  logic        press_pulse_q;
  logic [15:0] digits_q, digits_d;

  logic        press;
  logic        release_evt;
  logic        held;
  logic        hold_step;
  logic        long_clear;
  logic        count_en;
  logic [3:0]  at_max;
  logic [3:0]  carry_in;

  // Button edge classification against the previous sampled level.
  assign press       = ~pb_prev_q &  sw.pb_debounced;
  assign release_evt =  pb_prev_q & ~sw.pb_debounced;
  assign held        =  pb_prev_q &  sw.pb_debounced;

  // Hold counter only advances on a tick while held and below saturation;
  // the step that lands exactly on the threshold is the one-shot clear.
  assign hold_step  = held & sw.tick & (hold_q < HOLD_LIMIT);
  assign long_clear = hold_step & ((hold_q + 4'd1) == HOLD_LIMIT);

  // The clear takes priority over a coincident tick increment.
  assign count_en = sw.tick & (state_q == RUN) & ~long_clear;

  // Digit chain: digits 0/2 are units (0-9), digits 1/3 are tens (0-5).
  // Each digit advances when every lower digit is at its maximum, computed
  // directly from the registered digits so there is no ripple loop.
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    localparam logic [3:0] DIGIT_MAX  = (gi % 2 == 0) ? 4'd9 : 4'd5;
    localparam logic [3:0] LOWER_MASK = 4'((1 << gi) - 1);
    logic [3:0] cur_digit;

    assign cur_digit    = digits_q[gi*4 +: 4];
    assign at_max[gi]   = (cur_digit == DIGIT_MAX);
    assign carry_in[gi] = count_en & (&(at_max | ~LOWER_MASK));
    assign digits_d[gi*4 +: 4] = long_clear  ? 4'd0 :
                                 !carry_in[gi] ? cur_digit :
                                 at_max[gi]  ? 4'd0 : cur_digit + 4'd1;
  end

  // Next-state logic for run/pause, hold counter and long-press flag.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    long_flag_d = long_flag_q;

    if (press) begin
      hold_d = 4'd0;
    end else if (hold_step) begin
      hold_d = hold_q + 4'd1;
    end

    if (long_clear) begin
      state_d     = PAUSE;
      long_flag_d = 1'b1;
    end else if (release_evt) begin
      if (long_flag_q) begin
        long_flag_d = 1'b0;
      end else begin
        state_d = (state_q == RUN) ? PAUSE : RUN;
      end
    end
  end

  // State register for the run/pause FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PAUSE;
    end else begin
      state_q <= state_d;
    end
  end

  // Button tracking, hold counter, long-press flag and press pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pb_prev_q     <= 1'b0;
      hold_q        <= 4'd0;
      long_flag_q   <= 1'b0;
      press_pulse_q <= 1'b0;
    end else begin
      pb_prev_q     <= sw.pb_debounced;
      hold_q        <= hold_d;
      long_flag_q   <= long_flag_d;
      press_pulse_q <= press;
    end
  end

  // BCD display register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_q <= 16'd0;
    end else begin
      digits_q <= digits_d;
    end
  end

  assign sw.sec_ones    = digits_q[3:0];
  assign sw.sec_tens    = digits_q[7:4];
  assign sw.min_ones    = digits_q[11:8];
  assign sw.min_tens    = digits_q[15:12];
  assign sw.running     = (state_q == RUN);
  assign sw.press_pulse = press_pulse_q;

endmodule
